// File: rtl/pipe_stage_regs.sv
// Pipeline stage register with an optional two-entry skid buffer.
// It carries the instruction payload, the exception code and the slot flag together.
module pipe_stage_regs #(
    parameter int DW   = 160,
    parameter int EW   = 5,
    parameter int SKID = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [EW-1:0] in_exc,
    input  logic          in_slot,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [EW-1:0] out_exc,
    output logic          out_slot,
    output logic [1:0]    occupancy
);

    localparam int EN = DW + EW + 1;

    logic [EN-1:0] in_entry;
    logic [EN-1:0] main_entry;
    logic          clear;
    logic          xfer_in;
    logic          xfer_out;

    assign in_entry = {in_data, in_exc, in_slot};
    assign {out_data, out_exc, out_slot} = main_entry;
    assign clear    = reset | flush;
    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;

    // The head register is zeroed whenever it empties, so a bubble reads as a NOP.
    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

            state_t        state;
            logic [EN-1:0] skid_entry;
            logic          ready_q;

            always_ff @(posedge clk) begin
                if (clear) begin
                    state      <= EMPTY;
                    main_entry <= '0;
                    skid_entry <= '0;
                    ready_q    <= 1'b1;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (xfer_in) begin
                                state      <= ONE;
                                main_entry <= in_entry;
                            end
                        end
                        ONE: begin
                            if (xfer_in && xfer_out) begin
                                main_entry <= in_entry;
                            end else if (xfer_in) begin
                                state      <= TWO;
                                skid_entry <= in_entry;
                                ready_q    <= 1'b0;
                            end else if (xfer_out) begin
                                state      <= EMPTY;
                                main_entry <= '0;
                            end
                        end
                        TWO: begin
                            if (xfer_out) begin
                                state      <= ONE;
                                main_entry <= skid_entry;
                                skid_entry <= '0;
                                ready_q    <= 1'b1;
                            end
                        end
                        default: begin
                            state      <= EMPTY;
                            main_entry <= '0;
                            skid_entry <= '0;
                            ready_q    <= 1'b1;
                        end
                    endcase
                end
            end

            // Ready comes from a flop, so out_ready never reaches in_ready combinationally.
            assign in_ready  = ready_q;
            assign out_valid = (state != EMPTY);
            assign occupancy = state;
        end else begin : g_single
            logic vld;

            always_ff @(posedge clk) begin
                if (clear) begin
                    vld        <= 1'b0;
                    main_entry <= '0;
                end else if (xfer_in) begin
                    vld        <= 1'b1;
                    main_entry <= in_entry;
                end else if (xfer_out) begin
                    vld        <= 1'b0;
                    main_entry <= '0;
                end
            end

            assign in_ready  = ~vld | out_ready;
            assign out_valid = vld;
            assign occupancy = {1'b0, vld};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Bench for pipe_stage_regs: runs directed scenarios, then random traffic, on a skid
// instance and a single-register instance, and compares both against queue models.
module tb_pipe_stage_regs;

    localparam int DW = 160;
    localparam int EW = 5;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [EW-1:0] e;
        logic          s;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready, in_slot;
    logic [DW-1:0] in_data;
    logic [EW-1:0] in_exc;

    logic          in_ready1, out_valid1, out_slot1;
    logic [DW-1:0] out_data1;
    logic [EW-1:0] out_exc1;
    logic [1:0]    occupancy1;
    logic          in_ready0, out_valid0, out_slot0;
    logic [DW-1:0] out_data0;
    logic [EW-1:0] out_exc0;
    logic [1:0]    occupancy0;

    ent_t q1[$];
    ent_t q0[$];
    int   passes = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    pipe_stage_regs #(.DW(DW), .EW(EW), .SKID(1)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_exc(in_exc), .in_slot(in_slot),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_exc(out_exc1), .out_slot(out_slot1),
        .occupancy(occupancy1)
    );

    pipe_stage_regs #(.DW(DW), .EW(EW), .SKID(0)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_exc(in_exc), .in_slot(in_slot),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_exc(out_exc0), .out_slot(out_slot0),
        .occupancy(occupancy0)
    );

    task automatic cmp(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Model: a FIFO of capacity 2 (skid) or 1 (single); head shown, zeros when empty.
    task automatic cycle();
        bit   clr, xi1, xo1, xi0, xo0;
        ent_t cur, h1, h0;
        clr = reset || flush;
        xi1 = in_valid && (q1.size() < 2);
        xo1 = (q1.size() > 0) && out_ready;
        xi0 = in_valid && ((q0.size() == 0) || out_ready);
        xo0 = (q0.size() > 0) && out_ready;
        cur = '{d: in_data, e: in_exc, s: in_slot};
        @(posedge clk);
        #1;
        if (clr) begin
            q1.delete();
            q0.delete();
        end else begin
            if (xo1) void'(q1.pop_front());
            if (xi1) q1.push_back(cur);
            if (xo0) void'(q0.pop_front());
            if (xi0) q0.push_back(cur);
        end
        h1 = (q1.size() > 0) ? q1[0] : '0;
        h0 = (q0.size() > 0) ? q0[0] : '0;
        cmp("s1_out_valid", out_valid1, q1.size() > 0);
        cmp("s1_out_data", out_data1, h1.d);
        cmp("s1_out_exc", out_exc1, h1.e);
        cmp("s1_out_slot", out_slot1, h1.s);
        cmp("s1_occupancy", occupancy1, q1.size());
        cmp("s1_in_ready", in_ready1, q1.size() < 2);
        cmp("s0_out_valid", out_valid0, q0.size() > 0);
        cmp("s0_out_data", out_data0, h0.d);
        cmp("s0_out_exc", out_exc0, h0.e);
        cmp("s0_out_slot", out_slot0, h0.s);
        cmp("s0_occupancy", occupancy0, q0.size());
        cmp("s0_in_ready", in_ready0, (q0.size() == 0) || out_ready);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [EW-1:0] e,
                         input logic s, input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_exc    = e;
        in_slot   = s;
        out_ready = ordy;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cycle();
        cmp("reset_in_ready", in_ready1, 1'b1);
        cmp("reset_occ", occupancy1, 2'd0);
        reset = 1'b0;

        // Streaming 1,2,3,... with both sides always ready.
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, DW'(i), EW'(i), i[0], 1'b1);
            cycle();
            cmp("stream_data", out_data1, DW'(i));
            cmp("stream_occ", occupancy1, 2'd1);
            cmp("stream_ready", in_ready1, 1'b1);
        end

        // Backpressure: A and B accepted, C held off until the skid drains.
        flush = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cycle();
        flush = 1'b0;
        drive(1'b1, DW'('hA), 5'd1, 1'b0, 1'b0); cycle();
        drive(1'b1, DW'('hB), 5'd2, 1'b1, 1'b0); cycle();
        cmp("bp_ready_after_b", in_ready1, 1'b0);
        drive(1'b1, DW'('hC), 5'd3, 1'b0, 1'b0); cycle();
        cmp("bp_occ", occupancy1, 2'd2);
        cmp("bp_head_a", out_data1, DW'('hA));
        drive(1'b1, DW'('hC), 5'd3, 1'b0, 1'b1); cycle();
        cmp("bp_head_b", out_data1, DW'('hB));
        cmp("bp_slot_b", out_slot1, 1'b1);
        cycle();
        cmp("bp_head_c", out_data1, DW'('hC));

        // Flush while holding two, with a simultaneous offer.
        drive(1'b1, DW'('hD), 5'd4, 1'b0, 1'b0); cycle();
        drive(1'b1, DW'('hE), 5'd6, 1'b1, 1'b0); cycle();
        cmp("fl_pre_occ", occupancy1, 2'd2);
        flush = 1'b1;
        drive(1'b1, DW'('hF), 5'd7, 1'b1, 1'b0); cycle();
        flush = 1'b0;
        cmp("fl_valid", out_valid1, 1'b0);
        cmp("fl_data", out_data1, '0);
        cmp("fl_exc", out_exc1, '0);
        cmp("fl_occ", occupancy1, 2'd0);
        cmp("fl_ready", in_ready1, 1'b1);

        // Exception code stays with its payload through skid fill and drain.
        drive(1'b1, DW'('h10), 5'd5, 1'b0, 1'b0); cycle();
        drive(1'b1, DW'('h20), 5'd0, 1'b0, 1'b0); cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0); cycle();
        cmp("exc_head_data", out_data1, DW'('h10));
        cmp("exc_head_exc", out_exc1, 5'd5);
        drive(1'b0, '0, '0, 1'b0, 1'b1); cycle();
        cmp("exc_next_data", out_data1, DW'('h20));
        cmp("exc_next_exc", out_exc1, 5'd0);
        cycle();
        cmp("exc_drained", out_valid1, 1'b0);

        // Reset in the middle of a full stall, then a fresh transfer.
        drive(1'b1, DW'('h31), 5'd9, 1'b1, 1'b0); cycle();
        drive(1'b1, DW'('h32), 5'd8, 1'b1, 1'b0); cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cmp("rst_valid", out_valid1, 1'b0);
        cmp("rst_data", out_data1, '0);
        cmp("rst_slot", out_slot1, 1'b0);
        drive(1'b1, DW'('h44), 5'd3, 1'b0, 1'b0); cycle();
        cmp("rst_refill_valid", out_valid1, 1'b1);
        cmp("rst_refill_data", out_data1, DW'('h44));

        // Single-register variant: stall blocks, then accept-and-replace.
        drive(1'b1, DW'('h55), 5'd2, 1'b0, 1'b0); cycle();
        cmp("s0_stall_ready", in_ready0, 1'b0);
        cmp("s0_stall_occ", occupancy0, 2'd1);
        drive(1'b1, DW'('h66), 5'd1, 1'b1, 1'b1); cycle();
        cmp("s0_replace_data", out_data0, DW'('h66));
        cmp("s0_replace_valid", out_valid0, 1'b1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            flush = ($urandom_range(0, 29) == 0);
            reset = ($urandom_range(0, 59) == 0);
            drive(1'($urandom_range(0, 3) != 0),
                  {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()},
                  EW'($urandom()), 1'($urandom()), 1'($urandom_range(0, 2) != 0));
            cycle();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_regs.md
PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

Interface
REQ-001 SHALL have parameter DW, default 160, meaning payload width (IR, PC8, RS, RT, EXT concatenated).
REQ-002 SHALL have parameter EW, default 5, meaning exception-code width.
REQ-003 SHALL have parameter SKID, default 1; 1 = two-entry skid buffer, 0 = single register.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1 bit: synchronous clear, same effect as reset (interrupt or branch kill).
REQ-007 SHALL have port in_valid, input, 1 bit: upstream presents an instruction.
REQ-008 SHALL have port in_ready, output, 1 bit: stage can accept this cycle.
REQ-009 SHALL have port in_data, input, DW bits: instruction payload.
REQ-010 SHALL have port in_exc, input, EW bits: exception code carried with the payload.
REQ-011 SHALL have port in_slot, input, 1 bit: previous-instruction stall-and-jump flag.
REQ-012 SHALL have port out_valid, output, 1 bit: stage holds an instruction for downstream.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts this cycle.
REQ-014 SHALL have ports out_data (DW), out_exc (EW) and out_slot (1), all outputs, forming the head entry.
REQ-015 SHALL have port occupancy, output, 2 bits: entries held, 0..2.

Function
REQ-016 SHALL define transfer-in as in_valid & in_ready and transfer-out as out_valid & out_ready, both sampled at the same edge.
REQ-017 SHALL, with SKID=1, use states EMPTY (0 entries), ONE (main register valid) and TWO (main and skid valid).
REQ-018 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in TWO, registered so there is no combinational path from out_ready.
REQ-019 SHALL, from EMPTY, go to ONE on transfer-in (main <= input); otherwise stay in EMPTY.
REQ-020 SHALL, from ONE, act as follows: in + out -> ONE, main <= input; in only -> TWO, skid <= input; out only -> EMPTY; neither -> stay in ONE.
REQ-021 SHALL, from TWO, go to ONE on transfer-out (main <= skid); otherwise stay in TWO with contents unchanged.
REQ-022 SHALL, with SKID=0, hold one register with in_ready = ~out_valid | out_ready and occupancy never exceeding 1.
REQ-023 SHALL preserve FIFO order; out_* always present the oldest entry.
REQ-024 SHALL give 1-cycle latency from transfer-in to out_valid when the stage is empty.
REQ-025 SHALL force out_data, out_exc and out_slot to all zeros whenever out_valid = 0, so a bubble is a NOP with no exception.
REQ-026 SHALL make flush discard all entries: next state EMPTY, all storage zeroed, occupancy 0.
REQ-027 SHALL give flush priority over a simultaneous transfer-in; that input is lost, and upstream sees it as accepted if in_ready was 1.
REQ-028 SHALL leave storage unchanged while out_valid = 1 and out_ready = 0 (stall hold); no field may change.
REQ-029 SHALL carry in_exc and in_slot through exactly aligned with their payload in both the main and skid entries.

Reset
REQ-030 SHALL, on reset, set state EMPTY, all storage 0, out_valid 0, out_* 0, occupancy 0, and in_ready 1 on the following cycle.
REQ-031 SHALL, on reset mid-operation, drop held entries regardless of in_valid, out_ready or flush.
REQ-032 SHALL give reset and flush identical effect; their OR is the clear condition.

Verification
REQ-033 SHALL check streaming: in_valid=1 and out_ready=1 continuously with data 1,2,3,… -> out_data 1,2,3 one cycle later, occupancy 1, in_ready stays 1.
REQ-034 SHALL check backpressure: out_ready=0 while 3 words A,B,C are offered -> A and B accepted, in_ready=0 after B, occupancy 2; out_ready=1 -> A then B, then C accepted.
REQ-035 SHALL check flush in TWO with in_valid=1: next cycle out_valid=0, out_data=0, out_exc=0, occupancy 0, in_ready=1.
REQ-036 SHALL check exception alignment: payload 0x10 with exc 5, then 0x20 with exc 0, under skid fill and drain -> out pairs (0x10,5), (0x20,0).
REQ-037 SHALL check reset mid-stall (occupancy 2, out_ready=0): all outputs 0 next cycle, and a subsequent transfer-in gives out_valid 1 cycle later.
REQ-038 SHALL check SKID=0 with out_ready=0 and out_valid=1: in_ready=0 and occupancy 1; out_ready=1 with in_valid=1 -> accept-and-replace in the same cycle.
